window_gen_h_fp16: RTL and testbench
====================================

Name: window_gen_h_fp16

Overview:
- Horizontal sliding-window generator for the fp16 image pipeline.
- Takes a raster-order pixel stream and produces 1 x WINDOW_WIDTH windows, centre column/row tags and a valid strobe.
- Its outputs connect directly to the window_i/col_i/row_i/valid_i inputs of the box/convolution wrappers.
- Image borders are padded. A per-row flush emits the final RADIUS windows, with backpressure on the input while it runs.

Parameters:
- EXP_WIDTH, 5, fp exponent width.
- FRAC_WIDTH, 10, fp fraction width.
- WINDOW_WIDTH, 3, window width in pixels; must be odd and >= 3.
- WINDOW_HEIGHT, 1, fixed at 1; any other value is a hard elaboration error.
- IMAGE_WIDTH, 640, pixels per row.
- FP_WIDTH_REG, 1+FRAC_WIDTH+EXP_WIDTH, derived pixel width.
- RADIUS, (WINDOW_WIDTH-1)/2, derived.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- pixel_i  in  FP_WIDTH_REG  input pixel.
- col_i  in  16  column of pixel_i.
- row_i  in  16  row of pixel_i.
- valid_i  in  1  pixel_i/col_i/row_i valid.
- ready_o  out  1  block can accept; a transfer occurs when valid_i && ready_o at a rising edge.
- window_o  out  FP_WIDTH_REG [WINDOW_HEIGHT][WINDOW_WIDTH]  window; index 0 is the leftmost (oldest) pixel.
- col_o  out  16  centre column of window_o.
- row_o  out  16  row of window_o.
- valid_o  out  1  window_o/col_o/row_o valid, one-cycle pulse per window.

Behaviour:
- Reset (rst_i=0, takes effect immediately):
  - window_o, the shift register, col_o, row_o and valid_o are all 0.
  - ready_o=0; state=RUN.
  - ready_o goes to 1 as soon as rst_i deasserts.
- Shift register S[0..WINDOW_WIDTH-1]; S[WINDOW_WIDTH-1] is the newest pixel. PAD = 16'h0000 (+0.0).
- State RUN, ready_o=1. On a transfer:
  - col_i==0: S[0..W-2] <= PAD, S[W-1] <= pixel_i. Row-start reset; any pending windows from a truncated previous row are discarded.
  - Otherwise: S shifts left by one, S[W-1] <= pixel_i.
  - If col_i>=RADIUS: on the same edge, window_o <= the post-shift S, col_o <= col_i-RADIUS, row_o <= row_i, valid_o <= 1.
  - If col_i==IMAGE_WIDTH-1: next state FLUSH, flush counter k <= 0, latched row kept.
  - col_i>=IMAGE_WIDTH: transfer completes, pixel dropped, no state change.
- State FLUSH, ready_o=0 (driven directly from state, no registered lag):
  - Each cycle: shift in PAD, emit a window with col_o = IMAGE_WIDTH-RADIUS+k and row_o = latched row, valid_o=1, k++.
  - After RADIUS cycles, return to RUN.
  - valid_i is ignored while ready_o=0; upstream must hold its data.
- Latency:
  - Window for centre c < IMAGE_WIDTH-RADIUS: valid_o on the edge that accepts column c+RADIUS.
  - Flush windows: edges 1..RADIUS after the last-column accept.
- Output ordering and count:
  - Exactly IMAGE_WIDTH windows per complete row, in ascending col_o order.
  - Input gaps (valid_i=0) produce no windows, and the window contents are unchanged by them.
- valid_o is 0 in every cycle that has no emission; window_o/col_o/row_o hold their last value.
- Reset mid-FLUSH: remaining flush windows are not emitted; after release the block is in RUN with an empty register.

Optional Feature:
- Macro: WINDOW_GEN_REPLICATE_EN.
- Defined (edge replication instead of zero padding):
  - At row start, S[0..W-2] <= pixel_i.
  - In FLUSH, the shifted-in value is the last accepted pixel of the row.
- Undefined: PAD = 16'h0000 as above.
- Timing, handshake and window count are identical in both builds.

Test Plan:
1. Reset: hold rst_i=0 with valid_i=1 -> valid_o=0, ready_o=0, window_o all 0; release -> ready_o=1 the same cycle, nothing emitted until an accept.
2. WINDOW_WIDTH=3, IMAGE_WIDTH=4, row 0, pixels 3C00,4000,4200,4400 back-to-back -> windows in order:
   - col0 {0000,3C00,4000} on the col1 accept
   - col1 {3C00,4000,4200}
   - col2 {4000,4200,4400}
   - col3 {4200,4400,0000} in the single FLUSH cycle, with ready_o=0 that cycle
   - all with row_o=0.
3. Row 1 presented immediately after row 0 with valid_i held high -> first row-1 pixel is accepted only after ready_o returns to 1; exactly 4 valid_o pulses with row_o=1, col_o 0..3, no data loss.
4. Same row as test 2 with valid_i=0 for 2 cycles between each pixel -> identical window contents and order; valid_o only on accept/flush edges.
5. Assert rst_i during the FLUSH cycle of test 2 -> outputs go to 0 immediately, the col3 window is never emitted; after release, the next row starts clean from col0.
6. WINDOW_GEN_REPLICATE_EN defined, stimulus of test 2 -> col0 {3C00,3C00,4000}, col3 {4200,4400,4400}.

Source files
------------

// File: rtl/window_gen_h_fp16.sv
// window_gen_h_fp16: horizontal 1 x WINDOW_WIDTH sliding-window generator for
// a raster-order fp16 pixel stream, with border padding and a per-row flush.
// Optional build macro WINDOW_GEN_REPLICATE_EN: borders replicate the edge
// pixel instead of padding with +0.0.
module window_gen_h_fp16 #(
  parameter  int EXP_WIDTH     = 5,
  parameter  int FRAC_WIDTH    = 10,
  parameter  int WINDOW_WIDTH  = 3,
  parameter  int WINDOW_HEIGHT = 1,
  parameter  int IMAGE_WIDTH   = 640,
  localparam int FP_WIDTH_REG  = 1 + FRAC_WIDTH + EXP_WIDTH,
  localparam int RADIUS        = (WINDOW_WIDTH - 1) / 2
) (
  input  logic                                                         clk_i,
  input  logic                                                         rst_i,
  input  logic [FP_WIDTH_REG-1:0]                                      pixel_i,
  input  logic [15:0]                                                  col_i,
  input  logic [15:0]                                                  row_i,
  input  logic                                                         valid_i,
  output logic                                                         ready_o,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
  output logic [15:0]                                                  col_o,
  output logic [15:0]                                                  row_o,
  output logic                                                         valid_o
);

  if (WINDOW_HEIGHT != 1) begin : g_bad_height
    $error("window_gen_h_fp16: WINDOW_HEIGHT must be 1");
  end
  if ((WINDOW_WIDTH < 3) || ((WINDOW_WIDTH % 2) == 0)) begin : g_bad_width
    $error("window_gen_h_fp16: WINDOW_WIDTH must be odd and >= 3");
  end

  localparam int unsigned         WW         = WINDOW_WIDTH;
  localparam logic [15:0]         IW16       = 16'(IMAGE_WIDTH);
  localparam logic [15:0]         RAD16      = 16'(RADIUS);
  localparam logic [15:0]         LAST_COL   = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0]         FLUSH_BASE = 16'(IMAGE_WIDTH - RADIUS);
  localparam logic [FP_WIDTH_REG-1:0] PAD    = '0;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e                                                         state_q;
  logic [WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0]                      s_q;
  logic [WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0]                      s_d;
  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0]   win_q;
  logic [15:0]                                                    col_q;
  logic [15:0]                                                    row_q;
  logic                                                           valid_q;
  logic [15:0]                                                    k_q;
  logic [FP_WIDTH_REG-1:0]                                        fill;
  logic                                                           xfer;
  logic                                                           take;

  // Ready follows the state directly and is forced low while reset is held.
  assign ready_o  = rst_i & (state_q == RUN);
  assign xfer     = valid_i & ready_o;
  assign take     = xfer & (col_i < IW16);

  assign window_o = win_q;
  assign col_o    = col_q;
  assign row_o    = row_q;
  assign valid_o  = valid_q;

  // Next shift-register contents: row-start load, normal shift, or flush shift.
  always_comb begin
    fill = PAD;
    s_d  = s_q;
    if (state_q == FLUSH) begin
`ifdef WINDOW_GEN_REPLICATE_EN
      // The newest slot still holds the row's last pixel throughout the flush.
      fill = s_q[WINDOW_WIDTH-1];
`endif
      for (int unsigned i = 0; i < WW - 1; i++) begin
        s_d[i] = s_q[i+1];
      end
      s_d[WINDOW_WIDTH-1] = fill;
    end else if (take) begin
      if (col_i == '0) begin
`ifdef WINDOW_GEN_REPLICATE_EN
        fill = pixel_i;
`endif
        for (int unsigned i = 0; i < WW - 1; i++) begin
          s_d[i] = fill;
        end
      end else begin
        for (int unsigned i = 0; i < WW - 1; i++) begin
          s_d[i] = s_q[i+1];
        end
      end
      s_d[WINDOW_WIDTH-1] = pixel_i;
    end
  end

  // FSM with registered window outputs; valid_q is a one-cycle strobe.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      s_q     <= '0;
      win_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      k_q     <= '0;
    end else begin
      s_q     <= s_d;
      valid_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (take) begin
            if (col_i >= RAD16) begin
              win_q[0] <= s_d;
              col_q    <= col_i - RAD16;
              row_q    <= row_i;
              valid_q  <= 1'b1;
            end
            if (col_i == LAST_COL) begin
              state_q <= FLUSH;
              k_q     <= '0;
            end
          end
        end
        FLUSH: begin
          win_q[0] <= s_d;
          col_q    <= FLUSH_BASE + k_q;
          valid_q  <= 1'b1;
          k_q      <= k_q + 16'd1;
          if (k_q == RAD16 - 16'd1) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_window_gen_h_fp16.sv
// Scoreboard bench for window_gen_h_fp16 (WINDOW_WIDTH=3, IMAGE_WIDTH=4).
// Windows are predicted from a per-row pixel array with border padding.
module tb_window_gen_h_fp16;

  localparam int W  = 3;
  localparam int IW = 4;
  localparam int R  = (W - 1) / 2;
`ifdef WINDOW_GEN_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic                         clk_i;
  logic                         rst_i;
  logic [15:0]                  pixel_i;
  logic [15:0]                  col_i;
  logic [15:0]                  row_i;
  logic                         valid_i;
  logic                         ready_o;
  logic [0:0][W-1:0][15:0]      window_o;
  logic [15:0]                  col_o;
  logic [15:0]                  row_o;
  logic                         valid_o;

  window_gen_h_fp16 #(
    .EXP_WIDTH    (5),
    .FRAC_WIDTH   (10),
    .WINDOW_WIDTH (W),
    .WINDOW_HEIGHT(1),
    .IMAGE_WIDTH  (IW)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pixel_i (pixel_i),
    .col_i   (col_i),
    .row_i   (row_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .window_o(window_o),
    .col_o   (col_o),
    .row_o   (row_o),
    .valid_o (valid_o)
  );

  typedef struct {
    logic [W-1:0][15:0] w;
    int                 col;
    int                 row;
    int                 edge_n;
  } exp_t;

  exp_t        q[$];
  logic [15:0] rowbuf [IW];
  int          cyc    = 0;
  int          fe     = -100;
  int          errors = 0;
  int          checks = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  // Window centred on column c of the current row, borders padded.
  function automatic logic [W-1:0][15:0] mk(input int c);
    logic [W-1:0][15:0] r;
    for (int j = 0; j < W; j++) begin
      int idx;
      idx = c - R + j;
      if (idx < 0)        r[j] = REP ? rowbuf[0] : 16'h0000;
      else if (idx >= IW) r[j] = REP ? rowbuf[IW-1] : 16'h0000;
      else                r[j] = rowbuf[idx];
    end
    return r;
  endfunction

  function automatic void push(input int c, input int row, input int e);
    exp_t it;
    it.w      = mk(c);
    it.col    = c;
    it.row    = row;
    it.edge_n = e;
    q.push_back(it);
  endfunction

  // Pixel accepted at clock edge e: predict the windows it completes.
  function automatic void model_accept(input logic [15:0] px, input int col,
                                       input int row, input int e);
    if (col >= IW) return;
    rowbuf[col] = px;
    if (col >= R) push(col - R, row, e);
    if (col == IW - 1) begin
      fe = e;
      for (int k = 0; k < R; k++) push(IW - R + k, row, e + 1 + k);
    end
  endfunction

  // Starts and ends on a falling edge; holds the pixel until it is taken.
  task automatic send(input logic [15:0] px, input int col, input int row, input int gap);
    int waitc;
    for (int g = 0; g < gap; g++) begin
      valid_i = 1'b0;
      @(negedge clk_i);
    end
    pixel_i = px;
    col_i   = 16'(col);
    row_i   = 16'(row);
    valid_i = 1'b1;
    waitc   = 0;
    while (!ready_o && waitc < 50) begin
      @(negedge clk_i);
      waitc++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready_o=%b after %0d cycles, required 1", ready_o, waitc);
      valid_i = 1'b0;
      return;
    end
    model_accept(px, col, row, cyc + 1);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: ready_o every cycle, and every valid_o pulse against the queue.
  initial begin
    exp_t it;
    logic exp_rdy;
    forever begin
      @(negedge clk_i);
      exp_rdy = rst_i && !(cyc >= fe && cyc <= fe + R - 1);
      chk("ready", 64'(ready_o), 64'(exp_rdy));
      if (valid_o === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: col_o=%0d row_o=%0d at edge %0d, none required",
                   col_o, row_o, cyc);
        end else begin
          it = q.pop_front();
          chk("window", 64'(window_o[0]), 64'(it.w));
          chk("col",    64'(col_o),       64'(it.col));
          chk("row",    64'(row_o),       64'(it.row));
          chk("edge",   64'(cyc),         64'(it.edge_n));
        end
      end else if (valid_o !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL valid_x: got %b required 0/1", valid_o);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  logic [15:0] tp [4];

  initial begin
    tp[0] = 16'h3C00; tp[1] = 16'h4000; tp[2] = 16'h4200; tp[3] = 16'h4400;
    for (int i = 0; i < IW; i++) rowbuf[i] = 16'h0000;

    // Reset held with valid_i high.
    rst_i   = 1'b0;
    valid_i = 1'b1;
    pixel_i = 16'h1234;
    col_i   = 16'd0;
    row_i   = 16'd0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_valid",  64'(valid_o),  64'(0));
    chk("rst_ready",  64'(ready_o),  64'(0));
    chk("rst_window", 64'(window_o), 64'(0));
    chk("rst_col",    64'(col_o),    64'(0));
    chk("rst_row",    64'(row_o),    64'(0));
    @(negedge clk_i);
    #2;
    valid_i = 1'b0;
    rst_i   = 1'b1;
    #1;
    chk("release_ready", 64'(ready_o), 64'(1));
    repeat (4) @(negedge clk_i);

    // Row 0 back-to-back, then row 1 offered immediately during the flush.
    for (int c = 0; c < IW; c++) send(tp[c], c, 0, 0);
    chk("flush_ready", 64'(ready_o), 64'(0));
    for (int c = 0; c < IW; c++) send(16'($urandom), c, 1, 0);

    // Same row with two idle cycles between pixels.
    for (int c = 0; c < IW; c++) send(tp[c], c, 2, 2);

    // Reset asserted during the flush cycle.
    for (int c = 0; c < IW; c++) send(tp[c], c, 3, 0);
    #2;
    rst_i = 1'b0;
    fe    = -100;
    q.delete();
    #1;
    chk("midflush_valid",  64'(valid_o),  64'(0));
    chk("midflush_window", 64'(window_o), 64'(0));
    chk("midflush_col",    64'(col_o),    64'(0));
    chk("midflush_row",    64'(row_o),    64'(0));
    repeat (2) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midflush_release_ready", 64'(ready_o), 64'(1));
    @(negedge clk_i);
    for (int c = 0; c < IW; c++) send(tp[c], c, 4, 0);

    // Random rows: truncations, idle gaps, out-of-range columns.
    for (int r = 5; r < 70; r++) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, IW - 1)) : IW;
      for (int c = 0; c < len; c++) begin
        int gap;
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        if ($urandom_range(0, 9) == 0)
          send(16'($urandom), IW + int'($urandom_range(0, 10)), r, gap);
        send(16'($urandom), c, r, gap);
      end
    end

    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_windows: %0d still pending, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
